// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - command/result handshake bundle for alu_seq
//
// Purpose: groups the command channel (in_valid/in_ready, alu_cmd, inA, inB,
// sc_i) and the result channel (out_valid/out_ready, rslt and flags) of
// alu_seq into one interface.
// Ports (signals):
//   in_valid  1      command offered            (master -> slave)
//   in_ready  1      block can accept           (slave  -> master)
//   alu_cmd   3      operation select           (master -> slave)
//   inA, inB  WIDTH  operands                   (master -> slave)
//   sc_i      1      carry / shift-in           (master -> slave)
//   out_valid 1      result held                (slave  -> master)
//   out_ready 1      consumer takes result      (master -> slave)
//   rslt      WIDTH  result                     (slave  -> master)
//   sc_o, N, zero, V, E, G, err  1 each  flags  (slave  -> master)
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       alu_cmd;
  logic [WIDTH-1:0] inA;
  logic [WIDTH-1:0] inB;
  logic             sc_i;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] rslt;
  logic             sc_o;
  logic             N;
  logic             zero;
  logic             V;
  logic             E;
  logic             G;
  logic             err;

  modport master (
    output in_valid, alu_cmd, inA, inB, sc_i, out_ready,
    input  in_ready, out_valid, rslt, sc_o, N, zero, V, E, G, err
  );

  modport slave (
    input  in_valid, alu_cmd, inA, inB, sc_i, out_ready,
    output in_ready, out_valid, rslt, sc_o, N, zero, V, E, G, err
  );
endinterface

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequential ALU with iterative shifts and optional multiplier
//
// Purpose: accepts one command in IDLE, executes single-cycle ops straight
// into DONE and multi-cycle ops (shifts, multiply) through EXEC, then holds
// the registered result until the consumer takes it.
// Ports:
//   clk    1  rising-edge clock
//   rst_n  1  asynchronous active-low reset
//   bus       alu_seq_if.slave, command and result channels
// Configuration macro: ALU_MUL_EN -- when defined, cmd 111 is an iterative
// shift-add multiply; when undefined, cmd 111 returns err=1 in one cycle and
// no multiplier logic exists.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  alu_seq_if.slave bus
);

  localparam int SHW = $clog2(WIDTH);
  // counter must hold WIDTH for the multiply iteration count
  localparam int CW  = $clog2(WIDTH) + 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SHL = 3'b001;
  localparam logic [2:0] OP_SHR = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_CMP = 3'b101;
  localparam logic [2:0] OP_NOT = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       cmd_q, cmd_d;
  logic [WIDTH-1:0] wrk_q, wrk_d;     // shift operand, or multiplier bits
  logic             fill_q, fill_d;   // captured sc_i for shift fill
  logic [CW-1:0]    cnt_q, cnt_d;     // remaining EXEC iterations

  logic [WIDTH-1:0] rslt_q, rslt_d;
  logic             sc_o_q, sc_o_d;
  logic             n_q, n_d;
  logic             zero_q, zero_d;
  logic             v_q, v_d;
  logic             e_q, e_d;
  logic             g_q, g_d;
  logic             err_q, err_d;

`ifdef ALU_MUL_EN
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [2*WIDTH-1:0] prod_next;
`endif

  // result staging: whichever branch finishes a command fills these and
  // raises load, so the flag derivation lives in one place
  logic             load;
  logic [WIDTH-1:0] res;
  logic             res_sc;
  logic             res_v;
  logic             res_e;
  logic             res_g;
  logic             res_err;

  logic [WIDTH:0]   add_sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] shift_next;
  logic             shift_out;
  logic [SHW-1:0]   shamt;

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    wrk_d   = wrk_q;
    fill_d  = fill_q;
    cnt_d   = cnt_q;
    rslt_d  = rslt_q;
    sc_o_d  = sc_o_q;
    n_d     = n_q;
    zero_d  = zero_q;
    v_d     = v_q;
    e_d     = e_q;
    g_d     = g_q;
    err_d   = err_q;
`ifdef ALU_MUL_EN
    mcand_d   = mcand_q;
    prod_d    = prod_q;
    prod_next = prod_q + (wrk_q[0] ? mcand_q : '0);
`endif
    load    = 1'b0;
    res     = '0;
    res_sc  = 1'b0;
    res_v   = 1'b0;
    res_e   = 1'b0;
    res_g   = 1'b0;
    res_err = 1'b0;

    add_sum = {1'b0, bus.inA} + {1'b0, bus.inB} + {{WIDTH{1'b0}}, bus.sc_i};
    diff    = bus.inA - bus.inB;
    shamt   = bus.inB[SHW-1:0];

    if (cmd_q == OP_SHL) begin
      shift_next = {wrk_q[WIDTH-2:0], fill_q};
      shift_out  = wrk_q[WIDTH-1];
    end else begin
      shift_next = {fill_q, wrk_q[WIDTH-1:1]};
      shift_out  = wrk_q[0];
    end

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          cmd_d  = bus.alu_cmd;
          fill_d = bus.sc_i;
          case (bus.alu_cmd)
            OP_ADD: begin
              load    = 1'b1;
              res     = add_sum[WIDTH-1:0];
              res_sc  = add_sum[WIDTH];
              res_v   = (bus.inA[WIDTH-1] == bus.inB[WIDTH-1]) &&
                        (add_sum[WIDTH-1] != bus.inA[WIDTH-1]);
              state_d = S_DONE;
            end
            OP_SHL, OP_SHR: begin
              if (shamt == '0) begin
                load    = 1'b1;
                res     = bus.inA;
                state_d = S_DONE;
              end else begin
                wrk_d   = bus.inA;
                cnt_d   = CW'(shamt);
                state_d = S_EXEC;
              end
            end
            OP_AND: begin
              load    = 1'b1;
              res     = bus.inA & bus.inB;
              state_d = S_DONE;
            end
            OP_OR: begin
              load    = 1'b1;
              res     = bus.inA | bus.inB;
              state_d = S_DONE;
            end
            OP_CMP: begin
              load    = 1'b1;
              res     = diff;
              res_sc  = (bus.inA < bus.inB);
              res_v   = (bus.inA[WIDTH-1] != bus.inB[WIDTH-1]) &&
                        (diff[WIDTH-1] != bus.inA[WIDTH-1]);
              res_e   = (bus.inA != bus.inB);
              res_g   = (bus.inA > bus.inB);
              state_d = S_DONE;
            end
            OP_NOT: begin
              load    = 1'b1;
              res     = ~bus.inA;
              state_d = S_DONE;
            end
            default: begin
`ifdef ALU_MUL_EN
              prod_d  = '0;
              mcand_d = {{WIDTH{1'b0}}, bus.inA};
              wrk_d   = bus.inB;
              cnt_d   = CW'(WIDTH);
              state_d = S_EXEC;
`else
              load    = 1'b1;
              res_err = 1'b1;
              state_d = S_DONE;
`endif
            end
          endcase
        end
      end

      S_EXEC: begin
        cnt_d = cnt_q - CW'(1);
`ifdef ALU_MUL_EN
        if (cmd_q == OP_MUL) begin
          // one multiplier bit per cycle: add shifted multiplicand when set
          prod_d  = prod_next;
          mcand_d = mcand_q << 1;
          wrk_d   = wrk_q >> 1;
          if (cnt_q == CW'(1)) begin
            load    = 1'b1;
            res     = prod_next[WIDTH-1:0];
            res_sc  = |prod_next[2*WIDTH-1:WIDTH];
            state_d = S_DONE;
          end
        end else
`endif
        begin
          wrk_d = shift_next;
          // only the final shifted-out bit is reported, so it is taken
          // directly from the last iteration rather than stored each cycle
          if (cnt_q == CW'(1)) begin
            load    = 1'b1;
            res     = shift_next;
            res_sc  = shift_out;
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (load) begin
      rslt_d = res;
      sc_o_d = res_sc;
      n_d    = res[WIDTH-1];
      zero_d = (res == '0);
      v_d    = res_v;
      e_d    = res_e;
      g_d    = res_g;
      err_d  = res_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cmd_q   <= '0;
      wrk_q   <= '0;
      fill_q  <= 1'b0;
      cnt_q   <= '0;
      rslt_q  <= '0;
      sc_o_q  <= 1'b0;
      n_q     <= 1'b0;
      zero_q  <= 1'b0;
      v_q     <= 1'b0;
      e_q     <= 1'b0;
      g_q     <= 1'b0;
      err_q   <= 1'b0;
`ifdef ALU_MUL_EN
      mcand_q <= '0;
      prod_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      wrk_q   <= wrk_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      rslt_q  <= rslt_d;
      sc_o_q  <= sc_o_d;
      n_q     <= n_d;
      zero_q  <= zero_d;
      v_q     <= v_d;
      e_q     <= e_d;
      g_q     <= g_d;
      err_q   <= err_d;
`ifdef ALU_MUL_EN
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.rslt      = rslt_q;
  assign bus.sc_o      = sc_o_q;
  assign bus.N         = n_q;
  assign bus.zero      = zero_q;
  assign bus.V         = v_q;
  assign bus.E         = e_q;
  assign bus.G         = g_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq (WIDTH=8)
module tb_alu_seq;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  alu_seq_if #(.WIDTH(8)) bus ();

  alu_seq #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] r;
    logic [6:0] f;   // {sc_o, N, zero, V, E, G, err}
    int         lat;
  } exp_t;

  // reference model: results from plain integer arithmetic
  function automatic exp_t model(int cmd, int a, int b, int ci);
    exp_t x;
    int res, sc, v, e, g, er, lat, n, as, bs, s, p;
    res = 0; sc = 0; v = 0; e = 0; g = 0; er = 0; lat = 1;
    n  = b % 8;
    as = (a >= 128) ? a - 256 : a;
    bs = (b >= 128) ? b - 256 : b;
    case (cmd)
      0: begin
        s = a + b + ci; res = s % 256; sc = s / 256;
        s = as + bs + ci; v = (s > 127 || s < -128) ? 1 : 0;
      end
      1: begin
        if (n == 0) res = a;
        else begin
          res = ((a << n) | (ci != 0 ? (1 << n) - 1 : 0)) % 256;
          sc  = (a >> (8 - n)) & 1;
          lat = n + 1;
        end
      end
      2: begin
        if (n == 0) res = a;
        else begin
          res = (a >> n) | (ci != 0 ? (255 << (8 - n)) % 256 : 0);
          sc  = (a >> (n - 1)) & 1;
          lat = n + 1;
        end
      end
      3: res = a & b;
      4: res = a | b;
      5: begin
        res = (a - b + 256) % 256; sc = (a < b) ? 1 : 0;
        s = as - bs; v = (s > 127 || s < -128) ? 1 : 0;
        e = (a != b) ? 1 : 0; g = (a > b) ? 1 : 0;
      end
      6: res = 255 - a;
      default: begin
`ifdef ALU_MUL_EN
        p = a * b; res = p % 256; sc = (p / 256 != 0) ? 1 : 0; lat = 9;
`else
        p = 0; er = 1;
`endif
      end
    endcase
    x.r   = 8'(res);
    x.f   = {1'(sc), 1'(res >= 128), 1'(res == 0), 1'(v), 1'(e), 1'(g), 1'(er)};
    x.lat = lat;
    return x;
  endfunction

  task automatic check(input string tag, input int obs, input int exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  function automatic int flags();
    return int'({bus.sc_o, bus.N, bus.zero, bus.V, bus.E, bus.G, bus.err});
  endfunction

  // issue one command and wait for its result (no handshake)
  task automatic issue(input int cmd, input int a, input int b, input int ci,
                       input string tag);
    exp_t x;
    int lat;
    logic [7:0] prev;
    x = model(cmd, a, b, ci);
    @(negedge clk);
    check({tag, ".in_ready"}, int'(bus.in_ready), 1);
    prev         = bus.rslt;
    bus.in_valid = 1'b1;
    bus.alu_cmd  = 3'(cmd);
    bus.inA      = 8'(a);
    bus.inB      = 8'(b);
    bus.sc_i     = 1'(ci);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      check({tag, ".exec_hold"}, int'(bus.rslt), int'(prev));
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ".lat"}, lat, x.lat);
    check({tag, ".rslt"}, int'(bus.rslt), int'(x.r));
    check({tag, ".flags"}, flags(), int'(x.f));
  endtask

  task automatic handshake(input string tag);
    logic [7:0] r;
    int f;
    r = bus.rslt;
    f = flags();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({tag, ".ov_low"}, int'(bus.out_valid), 0);
    check({tag, ".rdy_back"}, int'(bus.in_ready), 1);
    check({tag, ".kept"}, int'(bus.rslt), int'(r));
    check({tag, ".kept_f"}, flags(), f);
  endtask

  task automatic run(input int cmd, input int a, input int b, input int ci,
                     input string tag);
    issue(cmd, a, b, ci, tag);
    handshake(tag);
  endtask

  initial begin
    logic [7:0] hold_r;
    int hold_f;
    checks = 0;
    errors = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.alu_cmd   = 3'd0;
    bus.inA       = 8'd0;
    bus.inB       = 8'd0;
    bus.sc_i      = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.out_valid", int'(bus.out_valid), 0);
    check("rst.in_ready", int'(bus.in_ready), 1);
    check("rst.rslt", int'(bus.rslt), 0);
    check("rst.flags", flags(), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // ADD overflow
    issue(0, 8'h7F, 8'h01, 0, "add7f");
    check("add7f.const_r", int'(bus.rslt), 8'h80);
    check("add7f.const_nv", int'({bus.N, bus.V, bus.sc_o}), 3'b110);
    handshake("add7f");

    // CMP greater, then backpressure while the result is held
    issue(5, 8'h09, 8'h03, 0, "cmp93");
    check("cmp93.const", int'({bus.rslt, bus.E, bus.G, bus.sc_o}), {8'h06, 3'b110});
    hold_r = bus.rslt;
    hold_f = flags();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.alu_cmd  = 3'(i);
      bus.inA      = 8'($urandom);
      bus.inB      = 8'($urandom);
      @(posedge clk); #1;
      check("bp.out_valid", int'(bus.out_valid), 1);
      check("bp.in_ready", int'(bus.in_ready), 0);
      check("bp.rslt", int'(bus.rslt), int'(hold_r));
      check("bp.flags", flags(), hold_f);
    end
    bus.in_valid = 1'b0;
    handshake("bp");

    run(5, 8'h05, 8'h05, 0, "cmp55");
    check("cmp55.const", int'({bus.zero, bus.E, bus.G}), 3'b100);

    issue(1, 8'h81, 3, 0, "shl3");
    check("shl3.const", int'({bus.rslt, bus.sc_o}), {8'h08, 1'b0});
    handshake("shl3");
    issue(2, 8'h81, 1, 1, "shr1");
    check("shr1.const", int'({bus.rslt, bus.sc_o}), {8'hC0, 1'b1});
    handshake("shr1");
    run(1, 8'hA5, 8'h08, 1, "shl0");

    issue(7, 8'h10, 8'h10, 0, "mul1010");
`ifdef ALU_MUL_EN
    check("mul1010.const", int'({bus.rslt, bus.sc_o, bus.zero}), {8'h00, 2'b11});
`else
    check("mul1010.err", int'({bus.rslt, bus.zero, bus.err}), {8'h00, 2'b11});
`endif
    handshake("mul1010");
    run(7, 8'h0F, 8'h11, 0, "mul0f11");

    // reset in the middle of a multi-cycle command
    run(0, 8'hFF, 8'hFF, 1, "pre_rst");
    @(negedge clk);
    bus.in_valid = 1'b1;
`ifdef ALU_MUL_EN
    bus.alu_cmd = 3'd7;
`else
    bus.alu_cmd = 3'd1;
`endif
    bus.inA = 8'hC3;
    bus.inB = 8'h07;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    check("mid_rst.out_valid", int'(bus.out_valid), 0);
    check("mid_rst.rslt", int'(bus.rslt), 0);
    check("mid_rst.flags", flags(), 0);
    check("mid_rst.in_ready", int'(bus.in_ready), 1);
    repeat (12) begin
      @(posedge clk); #1;
      check("rst_hold.out_valid", int'(bus.out_valid), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run(3, 8'hF0, 8'h3C, 0, "post_rst");

    // randomized commands against the model
    for (int i = 0; i < 40; i++) begin
      run(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
          int'($urandom_range(0, 255)), int'($urandom_range(0, 1)), "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, datapath width; legal values power of two, 4..32.
REQ-002 SHALL derive localparam SHW = $clog2(WIDTH), the shift-amount width.
REQ-003 SHALL have: clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have: rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have: in_valid input 1 command offered; in_ready output 1 block can accept.
REQ-006 SHALL have: alu_cmd input 3; inA, inB input WIDTH; sc_i input 1 carry/shift-in.
REQ-007 SHALL have: out_valid output 1 result held; out_ready input 1 consumer takes result.
REQ-008 SHALL have outputs: rslt WIDTH; sc_o, N, zero, V, E, G, err each 1; all registered.

Function
REQ-009 SHALL accept a command on a rising edge with in_valid & in_ready; in_ready = 1 only in IDLE.
REQ-010 SHALL implement FSM IDLE -> EXEC -> DONE -> IDLE; single-cycle ops go IDLE -> DONE directly.
REQ-011 SHALL in DONE assert out_valid and hold all outputs stable until out_valid & out_ready, then enter IDLE.
REQ-012 SHALL keep outputs at last value after handshake; in_valid ignored outside IDLE.
REQ-013 SHALL implement ADD (000): {sc_o,rslt} = inA+inB+sc_i; V = signed overflow; latency 1.
REQ-014 SHALL implement SHL (001)/SHR (010): shift inA by inB[SHW-1:0], one bit per EXEC cycle, vacated bits filled with sc_i; sc_o = last bit shifted out.
REQ-015 SHALL for shift amount 0 go to DONE with rslt = inA, sc_o = 0, latency 1; amount n>=1 gives latency n+1.
REQ-016 SHALL implement AND (011) and bitwise OR (100), sc_o = 0, latency 1.
REQ-017 SHALL implement CMP (101): rslt = inA-inB mod 2^WIDTH; sc_o = borrow (inA<inB unsigned); V = signed overflow; E = (inA!=inB); G = inA>inB unsigned; latency 1.
REQ-018 SHALL implement NOT (110): rslt = ~inA, latency 1.
REQ-019 SHALL implement MUL (111) as iterative shift-add, WIDTH EXEC cycles: rslt = low WIDTH bits of unsigned product; sc_o = OR of high WIDTH bits; latency WIDTH+1.
REQ-020 SHALL for all ops set zero = (rslt==0), N = rslt[WIDTH-1]; V, E, G = 0 except where stated; err = 0 except REQ-024.
REQ-021 SHALL keep rslt/flags unchanged while in EXEC; they update only on the edge entering DONE.

Reset
REQ-022 SHALL on rst_n low, immediately and regardless of state (including mid-EXEC): state IDLE, in_ready 1 after release, out_valid 0, rslt 0, sc_o/N/V/E/G/err 0, zero 0, internal counters 0.
REQ-023 SHALL discard any in-flight command on reset; no result is produced for it.

Configuration
REQ-024 SHALL gate MUL with macro ALU_MUL_EN: defined -> REQ-019; undefined -> cmd 111 completes in latency 1 with rslt 0, sc_o 0, zero 1, err 1, and no multiplier/iteration logic synthesised.

Verification (WIDTH=8)
REQ-025 SHALL check ADD 0x7F+0x01, sc_i=0 -> rslt 0x80, N=1, V=1, sc_o=0, out_valid the cycle after accept.
REQ-026 SHALL check CMP 0x09,0x03 -> rslt 0x06, E=1, G=1, sc_o=0; CMP 0x05,0x05 -> zero=1, E=0, G=0.
REQ-027 SHALL check SHL 0x81 by 3, sc_i=0 -> rslt 0x08, sc_o=0, latency 4; SHR 0x81 by 1, sc_i=1 -> rslt 0xC0, sc_o=1, latency 2.
REQ-028 SHALL check MUL 0x10*0x10 -> rslt 0x00, sc_o=1, zero=1, latency 9; MUL 0x0F*0x11 -> 0xFF, sc_o=0; without ALU_MUL_EN -> err=1.
REQ-029 SHALL check backpressure: out_ready=0 for 5 cycles after result -> outputs stable, in_ready=0, in_valid ignored; accept resumes one cycle after handshake.
REQ-030 SHALL check rst_n low at EXEC cycle 4 of MUL -> out_valid 0, all outputs 0, next command processed normally.
